chan_delay_line: RTL and testbench

//  Programmable integer-sample delay for the channel emulator IQ stream. Sits directly upstream of the

---
 rtl/chan_emu_pkg.sv | 18 +
 rtl/chan_delay_ram.sv | 24 ++
 rtl/chan_delay_line.sv | 137 +++++++++++++
 tb/tb_chan_delay_line.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_emu_pkg.sv
// Shared types for the channel emulator datapath: IQ sample layout and the delay-line FSM states.
package chan_emu_pkg;

    localparam int IQ_W     = 16;
    localparam int SAMPLE_W = 2 * IQ_W;

    typedef struct packed {
        logic [IQ_W-1:0] q;
        logic [IQ_W-1:0] i;
    } iq_sample_t;

    typedef enum logic [1:0] {
        UNCFG,
        FILL,
        RUN
    } delay_state_e;

endpackage

// File: rtl/chan_delay_ram.sv
// Simple dual-port sample history buffer: synchronous write, asynchronous read, no reset.
module chan_delay_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/chan_delay_line.sv
// Programmable integer-sample delay for the IQ stream (out[n] = in[n-D], zero prefix while filling).
// Optional macro CHAN_DELAY_ZERO_BYPASS_EN: zero-latency pass-through when running with D==0.
module chan_delay_line
    import chan_emu_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_W     = SAMPLE_W
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [DEPTH_LOG2-1:0] delay,
    input  logic                  delay_valid,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_W-1:0]     s_tdata,
    input  logic                  m_ready,
    output logic                  m_valid,
    output logic [DATA_W-1:0]     m_tdata,
    output logic                  primed
);

    localparam logic [DEPTH_LOG2-1:0] FILL_MAX = '1;

    delay_state_e          state_q, state_d;
    logic [DEPTH_LOG2-1:0] dly_q, dly_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] fill_cnt_q, fill_cnt_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_W-1:0]     m_tdata_q, m_tdata_d;

    logic                  accept;
    logic                  bypass;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [DATA_W-1:0]     rd_data;
    logic [DATA_W-1:0]     out_sample;

    chan_delay_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wr_ptr_q),
        .wr_data (s_tdata),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

`ifdef CHAN_DELAY_ZERO_BYPASS_EN
    // Bypass only once the output register has drained, so no sample can overtake a held one.
    assign bypass = (state_q == RUN) && (dly_q == '0) && !m_valid_q;
`else
    assign bypass = 1'b0;
`endif

    assign rd_addr = wr_ptr_q - dly_q;
    assign primed  = (state_q == RUN);
    assign accept  = s_valid && s_ready;

    always_comb begin
        s_ready = bypass ? m_ready : ((state_q != UNCFG) && (!m_valid_q || m_ready));
        m_valid = bypass ? s_valid : m_valid_q;
        m_tdata = bypass ? s_tdata : m_tdata_q;
    end

    // The RAM read sees the pre-write contents, so D==0 must take the live input instead.
    always_comb begin
        if (fill_cnt_q < dly_q) begin
            out_sample = '0;
        end else if (dly_q == '0) begin
            out_sample = s_tdata;
        end else begin
            out_sample = rd_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        wr_ptr_d   = wr_ptr_q;
        fill_cnt_d = fill_cnt_q;
        m_valid_d  = m_valid_q;
        m_tdata_d  = m_tdata_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (fill_cnt_q != FILL_MAX) begin
                fill_cnt_d = fill_cnt_q + 1'b1;
            end
        end

        if (accept && !bypass) begin
            m_valid_d = 1'b1;
            m_tdata_d = out_sample;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            UNCFG: begin
                if (delay_valid) begin
                    dly_d   = delay;
                    state_d = (delay == '0) ? RUN : FILL;
                end
            end
            FILL, RUN: begin
                // fill_cnt is never cleared, so a shrunken delay can resume from retained history.
                if (delay_valid) begin
                    dly_d   = delay;
                    state_d = (fill_cnt_d >= delay) ? RUN : FILL;
                end else begin
                    state_d = (fill_cnt_d >= dly_q) ? RUN : FILL;
                end
            end
            default: state_d = UNCFG;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q    <= UNCFG;
            dly_q      <= '0;
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            m_valid_q  <= 1'b0;
            m_tdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_cnt_q <= fill_cnt_d;
            m_valid_q  <= m_valid_d;
            m_tdata_q  <= m_tdata_d;
        end
    end

endmodule

// File: tb/tb_chan_delay_line.sv
// Directed self-checking bench for chan_delay_line: fill/zero prefix, D==0 latency, back-pressure,
// runtime delay changes, max-delay wrap and mid-stream reset.
module tb_chan_delay_line;

    logic        clk;
    logic        areset;
    logic [9:0]  delay;
    logic        delay_valid;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_tdata;
    logic        m_ready;
    logic        m_valid;
    logic [31:0] m_tdata;
    logic        primed;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] in_q[$];
    logic [31:0] out_q[$];
    bit          stab_en = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_data = '0;

    chan_delay_line #(
        .DEPTH_LOG2 (10),
        .DATA_W     (32)
    ) dut (
        .clk         (clk),
        .areset      (areset),
        .delay       (delay),
        .delay_valid (delay_valid),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_tdata     (s_tdata),
        .m_ready     (m_ready),
        .m_valid     (m_valid),
        .m_tdata     (m_tdata),
        .primed      (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Handshakes are sampled mid-cycle; inputs only change just after the rising edge.
    always @(negedge clk) begin
        if (areset) begin
            prev_hold = 1'b0;
        end else begin
            if (stab_en && prev_hold) begin
                check_output("hold_valid", {31'd0, m_valid}, 32'd1);
                check_output("hold_data", m_tdata, prev_data);
            end
            if (s_valid && s_ready) in_q.push_back(s_tdata);
            if (m_valid && m_ready) out_q.push_back(m_tdata);
            prev_hold = m_valid && !m_ready;
            prev_data = m_tdata;
        end
    end

    task automatic apply_stimulus_reset();
        areset      = 1'b1;
        s_valid     = 1'b0;
        delay_valid = 1'b0;
        m_ready     = 1'b1;
        @(posedge clk);
        #1;
        areset = 1'b0;
        in_q.delete();
        out_q.delete();
    endtask

    task automatic apply_stimulus_delay(input logic [9:0] val);
        delay       = val;
        delay_valid = 1'b1;
        @(posedge clk);
        #1;
        delay_valid = 1'b0;
    endtask

    task automatic apply_stimulus_one(input logic [31:0] data);
        bit ok = 1'b0;
        s_valid = 1'b1;
        s_tdata = data;
        for (int g = 0; g < 100 && !ok; g++) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        check_output("send_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic apply_stimulus_stream(input int n, input logic [31:0] base, input bit rnd);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 20 * n + 100) begin
            s_valid = 1'b1;
            s_tdata = base + k;
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (s_ready) k++;
            @(posedge clk);
            #1;
            guard++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        check_output("stream_timeout", {31'd0, k == n}, 32'd1);
    endtask

    task automatic apply_stimulus_drain();
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_shift(input string tag, input int d, input int n, input logic [31:0] base);
        logic [31:0] exp;
        check_output({tag, "_in_count"}, in_q.size(), n);
        check_output({tag, "_out_count"}, out_q.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < in_q.size()) check_output({tag, "_in"}, in_q[k], base + k);
            if (k < out_q.size()) begin
                exp = (k < d) ? 32'd0 : base + k - d;
                check_output({tag, "_out"}, out_q[k], exp);
            end
        end
    endtask

    initial begin
        areset      = 1'b1;
        delay       = '0;
        delay_valid = 1'b0;
        s_valid     = 1'b0;
        s_tdata     = '0;
        m_ready     = 1'b0;
        @(posedge clk);
        #1;
        areset = 1'b0;

        // Unconfigured: nothing accepted, nothing produced.
        check_output("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check_output("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check_output("rst_m_tdata", m_tdata, 32'd0);
        check_output("rst_primed", {31'd0, primed}, 32'd0);
        s_valid = 1'b1;
        s_tdata = 32'hDEAD_BEEF;
        m_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check_output("uncfg_s_ready", {31'd0, s_ready}, 32'd0);
            check_output("uncfg_m_valid", {31'd0, m_valid}, 32'd0);
            @(posedge clk);
            #1;
        end

        // Delay 3: zero prefix then shifted stream; primed after third accept.
        apply_stimulus_reset();
        apply_stimulus_delay(10'd3);
        check_output("d3_primed_0", {31'd0, primed}, 32'd0);
        apply_stimulus_one(32'd1);
        apply_stimulus_one(32'd2);
        check_output("d3_primed_2", {31'd0, primed}, 32'd0);
        apply_stimulus_one(32'd3);
        check_output("d3_primed_3", {31'd0, primed}, 32'd1);
        apply_stimulus_stream(17, 32'd4, 1'b0);
        apply_stimulus_drain();
        check_shift("d3", 3, 20, 32'd1);

        // Delay 0: latency depends on the bypass build option, values do not.
        apply_stimulus_reset();
        apply_stimulus_delay(10'd0);
        check_output("d0_primed", {31'd0, primed}, 32'd1);
        s_valid = 1'b1;
        s_tdata = 32'hA5A5_0001;
        m_ready = 1'b1;
        @(negedge clk);
`ifdef CHAN_DELAY_ZERO_BYPASS_EN
        check_output("d0_byp_valid", {31'd0, m_valid}, 32'd1);
        check_output("d0_byp_data", m_tdata, 32'hA5A5_0001);
`else
        check_output("d0_reg_valid_early", {31'd0, m_valid}, 32'd0);
`endif
        @(posedge clk);
        #1;
        s_valid = 1'b0;
`ifndef CHAN_DELAY_ZERO_BYPASS_EN
        check_output("d0_reg_valid", {31'd0, m_valid}, 32'd1);
        check_output("d0_reg_data", m_tdata, 32'hA5A5_0001);
`endif
        apply_stimulus_drain();
        in_q.delete();
        out_q.delete();
        apply_stimulus_stream(10, 32'h100, 1'b0);
        apply_stimulus_drain();
        check_shift("d0", 0, 10, 32'h100);

        // Delay 5 under random back-pressure with hold-stability monitoring.
        apply_stimulus_reset();
        apply_stimulus_delay(10'd5);
        stab_en = 1'b1;
        apply_stimulus_stream(1000, 32'h2000, 1'b1);
        apply_stimulus_drain();
        stab_en = 1'b0;
        check_shift("d5_bp", 5, 1000, 32'h2000);

        // Shrink 8 -> 2 with a same-cycle accept, then grow to 12 while history covers it.
        apply_stimulus_reset();
        apply_stimulus_delay(10'd8);
        apply_stimulus_stream(20, 32'd1, 1'b0);
        s_valid     = 1'b1;
        s_tdata     = 32'd21;
        delay       = 10'd2;
        delay_valid = 1'b1;
        @(posedge clk);
        #1;
        delay_valid = 1'b0;
        s_tdata     = 32'd22;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        apply_stimulus_delay(10'd12);
        apply_stimulus_one(32'd23);
        apply_stimulus_drain();
        check_output("chg_count", out_q.size(), 32'd23);
        if (out_q.size() == 23) begin
            check_output("chg_old_d8", out_q[19], 32'd12);
            check_output("chg_same_cycle", out_q[20], 32'd13);
            check_output("chg_shrink_d2", out_q[21], 32'd20);
            check_output("chg_grow_d12", out_q[22], 32'd11);
        end
        check_output("chg_primed", {31'd0, primed}, 32'd1);

        // Grow 2 -> 12 with too little history: zeros re-inserted until refilled.
        apply_stimulus_reset();
        apply_stimulus_delay(10'd2);
        apply_stimulus_stream(5, 32'd1, 1'b0);
        apply_stimulus_drain();
        check_output("grow_primed_pre", {31'd0, primed}, 32'd1);
        apply_stimulus_delay(10'd12);
        check_output("grow_primed_fill", {31'd0, primed}, 32'd0);
        apply_stimulus_one(32'd6);
        apply_stimulus_stream(7, 32'd7, 1'b0);
        apply_stimulus_drain();
        check_output("grow_count", out_q.size(), 32'd13);
        if (out_q.size() == 13) begin
            check_output("grow_pre", out_q[4], 32'd3);
            check_output("grow_zero_first", out_q[5], 32'd0);
            check_output("grow_zero_last", out_q[11], 32'd0);
            check_output("grow_history", out_q[12], 32'd1);
        end
        check_output("grow_primed_run", {31'd0, primed}, 32'd1);

        // Maximum delay across several pointer wraps.
        apply_stimulus_reset();
        apply_stimulus_delay(10'd1023);
        apply_stimulus_stream(3000, 32'h3000_0000, 1'b0);
        apply_stimulus_drain();
        check_shift("d1023", 1023, 3000, 32'h3000_0000);

        // Asynchronous reset in the middle of a stream.
        s_valid = 1'b1;
        s_tdata = 32'h7777_0000;
        m_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_output("mid_valid_pre", {31'd0, m_valid}, 32'd1);
        areset = 1'b1;
        #1;
        check_output("mid_valid", {31'd0, m_valid}, 32'd0);
        check_output("mid_s_ready", {31'd0, s_ready}, 32'd0);
        check_output("mid_primed", {31'd0, primed}, 32'd0);
        check_output("mid_tdata", m_tdata, 32'd0);
        @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        check_output("post_rst_s_ready", {31'd0, s_ready}, 32'd0);
        check_output("post_rst_m_valid", {31'd0, m_valid}, 32'd0);
        s_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
